// File: rtl/branch_pkg.sv
// Shared encodings for the branch predict unit: branch opcodes, 2-bit counter
// states, FSM state type and the saturating counter step.
package branch_pkg;

    localparam logic [3:0] BR_JMP = 4'b1000;
    localparam logic [3:0] BR_JZ  = 4'b1001;
    localparam logic [3:0] BR_JN  = 4'b1010;
    localparam logic [3:0] BR_JC  = 4'b1011;
    localparam logic [3:0] BR_JV  = 4'b1100;
    localparam logic [3:0] BR_JNZ = 4'b1101;
    localparam logic [3:0] BR_JNN = 4'b1110;
    localparam logic [3:0] BR_JNC = 4'b1111;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } bpu_state_e;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        if (taken) return (c == CTR_ST)  ? CTR_ST  : c + 2'd1;
        else       return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Condition decode: maps a branch encoding and the ALU flags to "condition holds".
module branch_cond
    import branch_pkg::*;
(
    input  logic [3:0] br,
    input  logic       z,
    input  logic       n,
    input  logic       c,
    input  logic       v,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (br)
            BR_JMP:  cond = 1'b1;
            BR_JZ:   cond = z;
            BR_JN:   cond = n;
            BR_JC:   cond = c;
            BR_JV:   cond = v;
            BR_JNZ:  cond = ~z;
            BR_JNN:  cond = ~n;
            BR_JNC:  cond = ~c;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution + 2-bit counter prediction table; a misprediction launches a
// fixed-length flush during which execute is ignored and predictions are forced off.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int IDX_W        = 4,
    parameter int ADDR_W       = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              pred_taken,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [3:0]        ex_branch,
    input  logic              ex_pred_taken,
    input  logic              z,
    input  logic              n,
    input  logic              c,
    input  logic              v,
    output logic              jump,
    output logic              mispredict,
    output logic              flush,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    bpu_state_e       state_q, state_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [1:0]       tbl_q [DEPTH];
    logic [1:0]       tbl_d [DEPTH];
    logic             mispredict_q, mispredict_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;

    logic             cond, resolve, miss;
    logic [IDX_W-1:0] f_idx, e_idx;

    assign f_idx = fetch_pc[IDX_W-1:0];
    assign e_idx = ex_pc[IDX_W-1:0];

    generate
        if (ADDR_W > IDX_W) begin : g_unused_pc
            logic unused_pc_hi;
            assign unused_pc_hi = ^{fetch_pc[ADDR_W-1:IDX_W], ex_pc[ADDR_W-1:IDX_W]};
        end
    endgenerate

    branch_cond u_cond (
        .br   (ex_branch),
        .z    (z),
        .n    (n),
        .c    (c),
        .v    (v),
        .cond (cond)
    );

    assign resolve    = ex_valid & ex_branch[3] & (state_q == ST_IDLE);
    assign jump       = resolve & cond;
    assign miss       = resolve & (jump != ex_pred_taken);
    // Table read is from the registered array, so a same-cycle update is not visible.
    assign pred_taken = fetch_valid & (state_q == ST_IDLE) & tbl_q[f_idx][1];

    always_comb begin
        tbl_d = tbl_q;
        if (resolve) tbl_d[e_idx] = ctr_step(tbl_q[e_idx], jump);

        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_IDLE: if (miss) begin
                state_d = ST_FLUSH;
                fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
            end
            ST_FLUSH: begin
                if (fcnt_q == '0) state_d = ST_IDLE;
                else              fcnt_d  = fcnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        mispredict_d = miss;
        flush_d      = (state_d == ST_FLUSH);
        miss_count_d = miss_count_q;
        if (miss && (miss_count_q != '1)) miss_count_d = miss_count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= CTR_WNT;
            state_q      <= ST_IDLE;
            fcnt_q       <= '0;
            mispredict_q <= 1'b0;
            flush_q      <= 1'b0;
            miss_count_q <= '0;
        end else begin
            tbl_q        <= tbl_d;
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            mispredict_q <= mispredict_d;
            flush_q      <= flush_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign mispredict = mispredict_q;
    assign flush      = flush_q;
    assign miss_count = miss_count_q;

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction unit for the pipelined core. It replaces the bare combinational jump decision with three things: an extended condition set, a table of 2-bit saturating counters indexed by PC, and misprediction detection. A misprediction drives a fixed-length pipeline flush sequence. Prediction is read at fetch; resolution, table update and flush control happen at execute.

## Interface
- `IDX_W`, default 4: table index width; the table has 2^IDX_W counters, indexed by `pc[IDX_W-1:0]`.
- `ADDR_W`, default 16: PC width; must be ≥ IDX_W.
- `FLUSH_CYCLES`, default 2: cycles `flush` stays high after a misprediction; must be ≥ 1.
- `CNT_W`, default 16: width of the saturating misprediction counter.
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `fetch_valid`, input, 1: fetch stage holds a branch needing a prediction.
- `fetch_pc`, input, ADDR_W: PC of the fetched branch.
- `pred_taken`, output, 1: prediction for `fetch_pc`. It is 0 when `fetch_valid`=0 or while flushing.
- `ex_valid`, input, 1: execute stage holds a valid instruction.
- `ex_pc`, input, ADDR_W: PC of the instruction in execute.
- `ex_branch`, input, 4: branch encoding (see Operation).
- `ex_pred_taken`, input, 1: the prediction made at fetch, carried down the pipeline.
- `z`, `n`, `c`, `v`, input, 1 each: flags.
- `jump`, output, 1: resolved outcome in execute (combinational).
- `mispredict`, output, 1: registered one-cycle pulse.
- `flush`, output, 1: registered; high for FLUSH_CYCLES cycles.
- `miss_count`, output, CNT_W: saturating count of mispredictions.

## Operation
- `ex_branch` encoding:
  - `0xxx`: not a branch.
  - `1000` JMP, `1001` JZ, `1010` JN, `1011` JC, `1100` JV.
  - `1101` JNZ, `1110` JNN, `1111` JNC.
- `jump` is asserted when `ex_valid`, the state is IDLE, `ex_branch[3]`=1, and the condition holds. JMP always holds. Otherwise `jump` is 0.
- A branch is resolved when `ex_valid` & `ex_branch[3]` & state==IDLE.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. All counters reset to 01.
- Prediction rule: `pred_taken = fetch_valid & state==IDLE & table[fetch_pc[IDX_W-1:0]][1]`.
- On resolution, the counter at `ex_pc[IDX_W-1:0]` updates at the clock edge:
  - increments if `jump`=1, saturating at 11;
  - decrements if `jump`=0, saturating at 00;
  - JMP increments like any taken branch.
- A misprediction is a resolution where `jump` ≠ `ex_pred_taken`. A non-branch instruction never mispredicts, even if `ex_pred_taken`=1.
- FSM:
  - IDLE → FLUSH on misprediction, loading the down-counter with FLUSH_CYCLES−1.
  - FLUSH → FLUSH while the counter ≠ 0, decrementing each cycle.
  - FLUSH → IDLE when the counter = 0.
- In FLUSH:
  - `ex_valid` is ignored: no resolution, no table update, no new misprediction.
  - `pred_taken` is forced to 0.
- `miss_count` increments on each misprediction and holds at 2^CNT_W−1.

## Timing
- Reset values:
  - counters 01, state IDLE, flush down-counter 0;
  - `mispredict` 0, `flush` 0, `miss_count` 0;
  - `pred_taken` 0 and `jump` 0 follow from the reset state.
- `pred_taken` and `jump` are combinational, with zero latency.
- A misprediction in cycle T gives `mispredict`=1 in cycle T+1 only, and `flush`=1 in cycles T+1 … T+FLUSH_CYCLES.
- `flush` is registered as (state==FLUSH), so it goes high in the cycle after the misprediction and stays high for exactly FLUSH_CYCLES cycles.
- The first resolution accepted after a flush is in cycle T+FLUSH_CYCLES+1.
- Same-index fetch read and execute write in one cycle: the read returns the old counter value, with no bypass.
- Back-to-back resolutions to the same index accumulate: each edge applies one step.
- Reset asserted mid-FLUSH: outputs clear immediately (asynchronous) and the state returns to IDLE.

## Structure
- Package `branch_pkg`:
  - the 4-bit branch encodings;
  - the 2-bit counter state constants;
  - the FSM state type (IDLE, FLUSH).
- Sub-module `branch_cond`: combinational evaluation of `ex_branch` and flags to a condition bit. It is the direct generalisation of the old jump decode.
- The top level holds the counter table (register array), the FSM, the flush down-counter and `miss_count`.

## Test plan
- Reset, then `fetch_valid`=1 at any PC → `pred_taken`=0. Resolve JZ with z=1 and `ex_pred_taken`=0 → `jump`=1, `mispredict` pulse, `flush` high 2 cycles, `miss_count`=1.
- Resolve JNZ at `ex_pc`=0x0005 twice with z=0 and the matching prediction each time → no mispredict. `pred_taken` at `fetch_pc`=0x0015 (same index) = 1, and the counter is at 11.
- Counter saturation: five taken, then one not-taken at one index → the counter reads 10 and the prediction stays 1.
- `ex_valid`=1 with a mispredicting JC during the FLUSH cycle after an earlier miss → no table change, no second pulse, `miss_count` unchanged.
- Non-branch (`ex_branch`=0011) with `ex_pred_taken`=1 → `jump`=0, no mispredict, table unchanged.
- Assert `rst` during the second flush cycle → `flush`, `mispredict` and `miss_count` go to 0 immediately. After release, all counters read 01.
